// File: rtl/txtscreen_ctrl.sv
// Fill/scroll engine for the 128x64 text buffer, sharing the buffer write port with CPU Wishbone writes.
// Define TXTSCREEN_CTRL_IRQ_EN to add the IRQ register (index 3) and a level interrupt on o_irq.
module txtscreen_ctrl #(
  parameter int COLS = 128,
  parameter int ROWS = 64
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [12:0] o_mem_wr_addr,
  output logic [15:0] o_mem_wr_data,
  output logic        o_mem_wren,
  output logic [12:0] o_mem_rd_addr,
  input  logic [15:0] i_mem_rd_data,
  output logic        o_busy,
  output logic        o_irq
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [6:0] ROW_LIM = 7'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_SC_RD = 3'd2,
    S_SC_WR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  row;
  logic [5:0]  row_nx;
  logic [5:0]  row_inc;
  logic [6:0]  col;
  logic [6:0]  col_nx;
  logic        col_last;

  logic [15:0] fill_reg;
  logic [5:0]  rg_first;
  logic [5:0]  rg_last;
  logic [15:0] c_fill;
  logic [5:0]  c_last;
  logic        done;
  logic        err;
`ifdef TXTSCREEN_CTRL_IRQ_EN
  logic        irq_en;
`endif

  // Handshake: a request is taken in any cycle with stb & cyc high and ack low;
  // ack follows in the next cycle and is forced low for the cycle after that.
  logic        wb_req;
  logic        cpu_wr;
  logic        reg_wr;
  logic [1:0]  reg_idx;
  logic [1:0]  cmd_op;
  logic        cmd_wr;
  logic        region_ok;
  logic        cmd_go;
  logic        cmd_bad;
  logic        eng_want;
  logic        eng_grant;
  logic [31:0] reg_rdata;
  logic        unused_bits;

  assign wb_req    = i_wb_stb & i_wb_cyc & ~o_wb_ack;
  assign cpu_wr    = wb_req & i_wb_we & ~i_wb_adr[15];
  assign reg_wr    = wb_req & i_wb_we & i_wb_adr[15];
  assign reg_idx   = i_wb_adr[3:2];
  assign cmd_op    = i_wb_dat[1:0];
  assign cmd_wr    = reg_wr && (reg_idx == 2'd0) && ((cmd_op == 2'd1) || (cmd_op == 2'd2));
  assign region_ok = (rg_first <= rg_last) && ({1'b0, rg_last} < ROW_LIM);
  assign cmd_go    = cmd_wr && (state == S_IDLE) && region_ok;
  assign cmd_bad   = cmd_wr && !cmd_go;

  // CPU buffer writes always win; the engine simply repeats its cycle when denied.
  assign eng_want  = (state == S_FILL) || (state == S_SC_WR);
  assign eng_grant = eng_want & ~cpu_wr;
  assign col_last  = (col == COL_MAX);
  assign row_inc   = row + 6'd1;

  assign o_busy      = (state != S_IDLE);
  assign unused_bits = ^{i_wb_adr[31:16], i_wb_adr[1:0], i_wb_dat[31:16]};

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    case (state)
      S_IDLE: begin
        if (cmd_go) begin
          row_nx = rg_first;
          col_nx = 7'd0;
          if ((cmd_op == 2'd2) && (rg_first != rg_last)) state_nx = S_SC_RD;
          else                                           state_nx = S_FILL;
        end
      end
      S_FILL: begin
        if (eng_grant) begin
          if (col_last) begin
            col_nx = 7'd0;
            if (row == c_last) state_nx = S_DONE;
            else               row_nx   = row_inc;
          end else begin
            col_nx = col + 7'd1;
          end
        end
      end
      S_SC_RD: state_nx = S_SC_WR;
      S_SC_WR: begin
        if (eng_grant) begin
          if (col_last) begin
            col_nx = 7'd0;
            row_nx = row_inc;
            // The bottom row has no source below it, so it is filled instead.
            if (row_inc == c_last) state_nx = S_FILL;
            else                   state_nx = S_SC_RD;
          end else begin
            col_nx   = col + 7'd1;
            state_nx = S_SC_RD;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_wren    = cpu_wr | eng_want;
    o_mem_wr_addr = 13'd0;
    o_mem_wr_data = 16'd0;
    if (cpu_wr) begin
      o_mem_wr_addr = i_wb_adr[14:2];
      o_mem_wr_data = i_wb_dat[15:0];
    end else if (state == S_FILL) begin
      o_mem_wr_addr = {row, col};
      o_mem_wr_data = c_fill;
    end else if (state == S_SC_WR) begin
      o_mem_wr_addr = {row, col};
      o_mem_wr_data = i_mem_rd_data;
    end
  end

  // Held through SC_WR so a stalled copy still sees valid read data.
  assign o_mem_rd_addr = ((state == S_SC_RD) || (state == S_SC_WR)) ? {row_inc, col} : 13'd0;

  always_comb begin
    reg_rdata = 32'd0;
    case (reg_idx)
      2'd0:    reg_rdata = {29'd0, err, done, o_busy};
      2'd1:    reg_rdata = {16'd0, fill_reg};
      2'd2:    reg_rdata = {18'd0, rg_last, 2'd0, rg_first};
`ifdef TXTSCREEN_CTRL_IRQ_EN
      default: reg_rdata = {30'd0, irq_en, done};
`else
      default: reg_rdata = 32'd0;
`endif
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state    <= S_IDLE;
      row      <= 6'd0;
      col      <= 7'd0;
      o_wb_ack <= 1'b0;
      o_wb_dat <= 32'd0;
      fill_reg <= 16'd0;
      rg_first <= 6'd0;
      rg_last  <= 6'd0;
      c_fill   <= 16'd0;
      c_last   <= 6'd0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef TXTSCREEN_CTRL_IRQ_EN
      irq_en   <= 1'b0;
      o_irq    <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      col      <= col_nx;
      o_wb_ack <= i_wb_stb & i_wb_cyc & ~o_wb_ack;
      if (wb_req) o_wb_dat <= (!i_wb_we && i_wb_adr[15]) ? reg_rdata : 32'd0;
      if (reg_wr && (reg_idx == 2'd1)) fill_reg <= i_wb_dat[15:0];
      if (reg_wr && (reg_idx == 2'd2)) begin
        rg_first <= i_wb_dat[5:0];
        rg_last  <= i_wb_dat[13:8];
      end
      if (cmd_go) begin
        c_fill <= fill_reg;
        c_last <= rg_last;
        done   <= 1'b0;
        err    <= 1'b0;
      end else if (cmd_bad) begin
        err <= 1'b1;
      end
`ifdef TXTSCREEN_CTRL_IRQ_EN
      if (reg_wr && (reg_idx == 2'd3)) begin
        if (i_wb_dat[0]) done   <= 1'b0;
        if (i_wb_dat[1]) irq_en <= 1'b1;
      end
      o_irq <= done & irq_en;
`endif
      if (state == S_DONE) done <= 1'b1;
    end
  end

`ifndef TXTSCREEN_CTRL_IRQ_EN
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_txtscreen_ctrl.sv
// Bench for txtscreen_ctrl: directed cases plus random fill/scroll commands checked against
// a row-level buffer model, an ordered queue of expected engine writes and cycle-count formulas.
module tb_txtscreen_ctrl;

  localparam int COLS = 128;
  localparam int ROWS = 64;
  localparam logic [31:0] A_CTRL   = 32'h0000_8000;
  localparam logic [31:0] A_FILL   = 32'h0000_8004;
  localparam logic [31:0] A_REGION = 32'h0000_8008;
  localparam logic [31:0] A_IRQ    = 32'h0000_800C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic [12:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_wren;
  logic [12:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        busy;
  logic        irq;

  txtscreen_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_wb_clk      (clk),
    .i_wb_rst_n    (rst_n),
    .i_wb_adr      (wb_adr),
    .i_wb_dat      (wb_dat_w),
    .i_wb_we       (wb_we),
    .i_wb_stb      (wb_stb),
    .i_wb_cyc      (wb_cyc),
    .o_wb_dat      (wb_dat_r),
    .o_wb_ack      (wb_ack),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_wren    (mem_wren),
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_busy        (busy),
    .o_irq         (irq)
  );

  // Buffer RAM with one-clock read latency, plus a bench-side load port.
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic [15:0] mem [8192];
  always @(posedge clk) begin
    if (bd_we)         mem[bd_addr] <= bd_data;
    else if (mem_wren) mem[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_rd_addr];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_mem [8192];
  logic [28:0] exp_q [$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          busy_total = 0;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic        cpu_now;
  logic [31:0] eng_exp;

  assign cpu_now = wb_stb & wb_cyc & wb_we & ~wb_adr[15] & ~wb_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every engine write must be the next entry of exp_q; CPU writes must pass straight through.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_total++;
      if (cpu_now) begin
        check("cpu_port", {2'b0, mem_wren, mem_wr_addr, mem_wr_data},
              {2'b0, 1'b1, wb_adr[14:2], wb_dat_w[15:0]});
      end else if (mem_wren) begin
        eng_exp = (exp_q.size() > 0) ? {3'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
        check("eng_wr", {3'b0, mem_wr_addr, mem_wr_data}, eng_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    @(posedge clk); #1;
    wb_adr = adr; wb_dat_w = dat; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    check("wb_ack", {31'd0, wb_ack}, 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    @(posedge clk); #1;
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    dat = wb_dat_r;
  endtask

  task automatic buf_write(input logic [12:0] addr, input logic [15:0] data);
    wb_write({17'd0, addr, 2'b00}, {16'd0, data});
    exp_mem[addr] = data;
  endtask

  task automatic bd_load(input int base, input int n, input bit rnd, input logic [15:0] val);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bd_we = 1'b1;
      bd_addr = 13'(base + i);
      bd_data = rnd ? 16'($urandom) : val;
      exp_mem[base + i] = bd_data;
    end
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
    @(posedge clk); #1;
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Row-level reference: fill sets whole rows, scroll copies each row from the one below.
  task automatic model_cmd(input int op, input int first, input int last, input logic [15:0] fill);
    logic [15:0] v;
    if (op == 2) begin
      for (int r = first; r < last; r++)
        for (int c = 0; c < COLS; c++) begin
          v = exp_mem[(r + 1) * 128 + c];
          exp_mem[r * 128 + c] = v;
          exp_q.push_back({13'(r * 128 + c), v});
        end
      for (int c = 0; c < COLS; c++) begin
        exp_mem[last * 128 + c] = fill;
        exp_q.push_back({13'(last * 128 + c), fill});
      end
    end else begin
      for (int r = first; r <= last; r++)
        for (int c = 0; c < COLS; c++) begin
          exp_mem[r * 128 + c] = fill;
          exp_q.push_back({13'(r * 128 + c), fill});
        end
    end
  endtask

  function automatic int cmd_cycles(input int op, input int first, input int last);
    if (op == 2) return 2 * (last - first) * COLS + COLS;
    return (last - first + 1) * COLS;
  endfunction

  task automatic final_checks();
    logic [31:0] st;
    int          nd;
    wb_read(A_CTRL, st);
    check("status", st, {29'd0, exp_err, exp_done, 1'b0});
    check("q_drain", exp_q.size(), 0);
    nd = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== exp_mem[i]) nd++;
    check("mem_diff", nd, 0);
  endtask

  task automatic setup_region(input int first, input int last, input logic [15:0] fill);
    wb_write(A_FILL, {16'd0, fill});
    wb_write(A_REGION, {18'd0, 6'(last), 2'd0, 6'(first)});
  endtask

  task automatic run_cmd(input int op, input int first, input int last, input logic [15:0] fill);
    bit ok;
    int b0;
    int cyc_exp;
    ok = (first <= last) && (last < ROWS);
    setup_region(first, last, fill);
    if (ok) model_cmd(op, first, last, fill);
    cyc_exp = ok ? cmd_cycles(op, first, last) + 1 : 0;
    b0 = busy_total;
    wb_write(A_CTRL, 32'(op));
    check("busy_t1", {31'd0, busy}, {31'd0, ok});
    check("wren_t1", {31'd0, mem_wren}, {31'd0, ok && (op == 1 || first == last)});
    if (ok && op == 2 && first != last)
      check("rd_addr_t1", {19'd0, mem_rd_addr}, {19'd0, 6'(first + 1), 7'd0});
    wait_idle();
    check("busy_cycles", busy_total - b0, cyc_exp);
    if (ok) begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    final_checks();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd;
    int          b0;
    int          op;
    int          first;
    int          last;

    bd_load(0, 8192, 1'b1, 16'd0);
    @(negedge clk);
    check("rst_outs", {10'd0, busy, mem_wren, wb_ack, irq, mem_rd_addr, 5'd0},
          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    wb_read(A_CTRL, rd);
    check("rst_status", rd, 32'd0);
    wb_read(A_FILL, rd);
    check("rst_fill", rd, 32'd0);
    wb_read(A_REGION, rd);
    check("rst_region", rd, 32'd0);
    check("rst_idle", {29'd0, busy, mem_wren, irq}, 32'd0);

    // Fill rows 2..3
    run_cmd(1, 2, 3, 16'h0720);
    check("fill_first", {16'd0, mem[13'h100]}, 32'h0720);
    check("fill_last", {16'd0, mem[13'h1FF]}, 32'h0720);
    wb_read(A_REGION, rd);
    check("region_rb", rd, 32'h0000_0302);
    wb_read(32'h0000_0400, rd);
    check("buf_read_zero", rd, 32'd0);

    // Scroll rows 5..6
    bd_load(5 * 128, 128, 1'b0, 16'hAAAA);
    bd_load(6 * 128, 128, 1'b0, 16'h5555);
    run_cmd(2, 5, 6, 16'h0000);
    check("scroll_r5", {16'd0, mem[5 * 128 + 3]}, 32'h5555);
    check("scroll_r6", {16'd0, mem[6 * 128 + 100]}, 32'h0000);

    // CPU writes every 4th cycle while row 0 fills
    setup_region(0, 0, 16'h0720);
    model_cmd(1, 0, 0, 16'h0720);
    b0 = busy_total;
    wb_write(A_CTRL, 32'd1);
    for (int k = 0; k < 40; k++) begin
      repeat (2) @(posedge clk);
      buf_write(13'h040, 16'h1234);
    end
    wait_idle();
    check("stall_cycles", busy_total - b0, COLS + 40 + 1);
    check("stall_cell", {16'd0, mem[13'h040]}, 32'h1234);
    check("stall_nbr", {16'd0, mem[13'h041]}, 32'h0720);
    exp_done = 1'b1;
    exp_err  = 1'b0;
    final_checks();

    // Bad region: no writes, err set
    run_cmd(1, 10, 9, 16'hBEEF);

    // Command while busy is rejected, in-flight command unaffected
    setup_region(20, 21, 16'h0F0F);
    model_cmd(1, 20, 21, 16'h0F0F);
    b0 = busy_total;
    wb_write(A_CTRL, 32'd1);
    repeat (10) @(posedge clk);
    wb_write(A_CTRL, 32'd2);
    wait_idle();
    check("rej_busy_cycles", busy_total - b0, 2 * COLS + 1);
    exp_done = 1'b1;
    exp_err  = 1'b1;
    final_checks();

    // Command landing in the DONE cycle is rejected
    setup_region(30, 30, 16'h1111);
    model_cmd(1, 30, 30, 16'h1111);
    b0 = busy_total;
    wb_write(A_CTRL, 32'd1);
    repeat (COLS - 1) @(posedge clk);
    wb_write(A_CTRL, 32'd1);
    wait_idle();
    check("rej_done_cycles", busy_total - b0, COLS + 1);
    exp_done = 1'b1;
    exp_err  = 1'b1;
    final_checks();

    // No-op command code
    wb_write(A_CTRL, 32'd3);
    repeat (3) @(posedge clk); #1;
    check("noop_busy", {31'd0, busy}, 32'd0);
    final_checks();

`ifdef TXTSCREEN_CTRL_IRQ_EN
    wb_write(A_IRQ, 32'd2);
    setup_region(40, 40, 16'h2222);
    model_cmd(1, 40, 40, 16'h2222);
    wb_write(A_CTRL, 32'd1);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, irq}, 32'd1);
    wb_write(A_IRQ, 32'd1);
    repeat (2) @(negedge clk);
    check("irq_clear", {31'd0, irq}, 32'd0);
    wb_read(A_IRQ, rd);
    check("irq_reg", rd, 32'd2);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    final_checks();
`else
    wb_write(A_IRQ, 32'd3);
    wb_read(A_IRQ, rd);
    check("irq_reg_zero", rd, 32'd0);
    check("irq_tied", {31'd0, irq}, 32'd0);
    final_checks();
`endif

    // Random commands with random buffer traffic between them
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 3; k++) buf_write(13'($urandom_range(0, 8191)), 16'($urandom));
      op    = $urandom_range(1, 2);
      first = $urandom_range(0, 62);
      last  = first + $urandom_range(0, 2);
      if (last > 63) last = 63;
      if ($urandom_range(0, 5) == 0 && last < 63) first = last + 1;
      run_cmd(op, first, last, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
